// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer_counter slice: state encoding and
// default sizing constants.
package down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } state_t;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/down_timer_prescaler.sv
// Prescaler for down_timer_counter: divides enabled RUN edges by PRESCALE.
// tick is high on the enabled edge on which the internal counter wraps.
// Used by the top only when DOWN_TIMER_PRESCALE_EN is defined.
module down_timer_prescaler
    import down_timer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = enable && (cnt_q == LAST);

    // Next prescale count: restart zeroes, each enabled edge advances and wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = 8'd0;
        end else if (enable) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        end
    end

    // Prescale counter register, falling-edge clocked like the rest of the timer.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/down_timer_counter.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse and
// optional auto-reload. Define DOWN_TIMER_PRESCALE_EN to divide the count
// rate by PRESCALE; without it every enabled RUN edge decrements.
module down_timer_counter
    import down_timer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // An edge that may advance the count: running, enabled, not overridden.
    logic step_en;
    logic tick;

    assign step_en = (state_q == ST_RUN) && enable && !clear && !load;

`ifdef DOWN_TIMER_PRESCALE_EN
    down_timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (clear || load),
        .enable  (step_en),
        .tick    (tick)
    );
`else
    // Without the prescaler every enabled edge counts; PRESCALE only has to
    // be within its legal range, which folds to a constant 1 here.
    localparam logic PRESCALE_LEGAL = (PRESCALE >= 1) && (PRESCALE <= 255);
    assign tick = step_en && PRESCALE_LEGAL;
`endif

    // Next-state: clear beats load beats decrement; tc only on the q==1 event.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (clear) begin
            count_d = '0;
            state_d = ST_IDLE;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? ST_RUN : ST_IDLE;
        end else if (tick) begin
            if (count_q == WIDTH'(1)) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // State, count, reload and tc registers, updated on the falling clock edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign q    = count_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_down_timer_counter.sv
// Self-checking bench for down_timer_counter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a model.
module tb_down_timer_counter;

`ifdef DOWN_TIMER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       enable = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] q;
    logic       tc;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model state: plain integers describing the timer's externally visible rules.
    int m_q = 0;
    int m_reload = 0;
    bit m_run = 1'b0;
    bit m_tc = 1'b0;
    int m_pre = 0;

    down_timer_counter #(.WIDTH(4), .PRESCALE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .load        (load),
        .load_val    (load_val),
        .enable      (enable),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour applied at each falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            m_q = 0; m_reload = 0; m_run = 0; m_tc = 0; m_pre = 0;
        end else begin
            m_tc = 0;
            if (clear) begin
                m_q = 0; m_run = 0; m_pre = 0;
            end else if (load) begin
                m_q = int'(load_val);
                m_reload = int'(load_val);
                m_run = (load_val != 0);
                m_pre = 0;
            end else if (m_run && enable) begin
                m_pre = m_pre + 1;
                if (m_pre == PS) begin
                    m_pre = 0;
                    if (m_q == 1) begin
                        m_tc = 1;
                        if (auto_reload) m_q = m_reload;
                        else begin m_q = 0; m_run = 0; end
                    end else begin
                        m_q = m_q - 1;
                    end
                end
            end
        end
    end

    always @(negedge reset) begin
        m_q = 0; m_reload = 0; m_run = 0; m_tc = 0; m_pre = 0;
    end

    // Every-cycle comparison against the model, half a cycle after the update.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("model_q", int'(q), m_q);
            check("model_tc", int'(tc), int'(m_tc));
            check("model_busy", int'(busy), int'(m_run));
            if (busy) check("q_nonzero_in_run", int'(q != 4'd0), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit en, input bit ar);
        clear = c; load = l; load_val = 4'(lv); enable = en; auto_reload = ar;
    endtask

    task automatic expect3(input string name, input int eq, input int etc, input int ebusy);
        check({name, "_q"}, int'(q), eq);
        check({name, "_tc"}, int'(tc), etc);
        check({name, "_busy"}, int'(busy), ebusy);
    endtask

    initial begin
        #1 reset = 1'b0;
        step();
        reset = 1'b1;
        chk_en = 1'b1;
        expect3("after_reset", 0, 0, 0);

`ifndef DOWN_TIMER_PRESCALE_EN
        // Reset mid-count: outputs drop without a clock edge.
        drive(0, 1, 7, 0, 0); step();
        drive(0, 0, 0, 1, 0); step();
        expect3("pre_reset", 6, 0, 1);
        reset = 1'b0;
        #1 expect3("async_reset", 0, 0, 0);
        step();
        reset = 1'b1; step();
        expect3("post_reset", 0, 0, 0);
        $display("reset mid-count done");

        // One-shot from 5.
        drive(0, 1, 5, 0, 0); step();
        expect3("oneshot_load", 5, 0, 1);
        drive(0, 0, 0, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            step(); expect3("oneshot_cnt", i, 0, 1);
        end
        step(); expect3("oneshot_tc", 0, 1, 0);
        step(); expect3("oneshot_after", 0, 0, 0);
        $display("one-shot 5 done");

        // Auto-reload from 3 with an enable gap.
        drive(0, 1, 3, 0, 1); step();
        expect3("ar_load", 3, 0, 1);
        drive(0, 0, 0, 1, 1);
        step(); expect3("ar_2", 2, 0, 1);
        step(); expect3("ar_1", 1, 0, 1);
        step(); expect3("ar_tc1", 3, 1, 1);
        step(); expect3("ar_2b", 2, 0, 1);
        enable = 1'b0;
        step(); expect3("ar_hold1", 2, 0, 1);
        step(); expect3("ar_hold2", 2, 0, 1);
        enable = 1'b1;
        step(); expect3("ar_1b", 1, 0, 1);
        step(); expect3("ar_tc2", 3, 1, 1);
        $display("auto-reload 3 done");

        // Load of 9 at q==1 restarts without tc.
        drive(0, 1, 2, 0, 0); step();
        drive(0, 0, 0, 1, 0); step();
        expect3("pri_q1", 1, 0, 1);
        drive(0, 1, 9, 1, 0); step();
        expect3("pri_load9", 9, 0, 1);
        drive(1, 1, 6, 1, 0); step();
        expect3("pri_clear_load", 0, 0, 0);
        drive(0, 1, 0, 1, 1); step();
        expect3("pri_zero_load", 0, 0, 0);
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(); expect3("pri_zero_idle", 0, 0, 0);
        end
        $display("priorities done");

        // Full-scale count from 15.
        drive(0, 1, 15, 0, 0); step();
        drive(0, 0, 0, 1, 0);
        for (int i = 1; i <= 14; i++) begin
            step(); expect3("wrap_cnt", 15 - i, 0, 1);
        end
        step(); expect3("wrap_tc", 0, 1, 0);
        $display("full-scale 15 done");
`else
        // Prescaled count from 2 with auto-reload: period 8 enabled edges.
        drive(0, 1, 2, 0, 1); step();
        expect3("ps_load", 2, 0, 1);
        drive(0, 0, 0, 1, 1);
        for (int i = 1; i <= 3; i++) begin
            step(); expect3("ps_hold2", 2, 0, 1);
        end
        for (int i = 4; i <= 7; i++) begin
            step(); expect3("ps_hold1", 1, 0, 1);
        end
        step(); expect3("ps_tc1", 2, 1, 1);
        for (int i = 1; i <= 7; i++) begin
            step(); check("ps_no_tc", int'(tc), 0);
        end
        step(); expect3("ps_tc2", 2, 1, 1);
        $display("prescale 2x4 done");
`endif

        // Randomized traffic, checked every cycle by the model comparison.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            clear = (r < 4);
            load = (r >= 4) && (r < 20);
            load_val = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            enable = ($urandom_range(0, 3) != 0);
            auto_reload = ($urandom_range(0, 1) == 1);
            if (r == 199) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            if (load && !clear && (n % 100 == 0))
                $display("random load %0d auto_reload %0d", load_val, auto_reload);
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
